// File: rtl/pipe_hazard_if.sv
// Hazard-unit bus: per-stage register/hazard info toward the controller,
// stage enables, bubble requests and forwarding selects back to the datapath.
interface pipe_hazard_if;
  logic [4:0] dRs, dRt;
  logic       dUseRs, dUseRt;
  logic [4:0] eRs, eRt, eRd;
  logic       eWreg, eReg2reg;
  logic [4:0] mRd;
  logic       mWreg, mReg2reg, mMemReq, memRdy;
  logic [4:0] wRd;
  logic       wWreg;
  logic       branch;
  logic       pcEn, enIfid, enIdex, enExmem, enMemwb;
  logic       flushIfid, flushIdex, flushExmem, flushMemwb;
  logic [1:0] fwdA, fwdB;

  modport master (
    output dRs, dRt, dUseRs, dUseRt, eRs, eRt, eRd, eWreg, eReg2reg,
           mRd, mWreg, mReg2reg, mMemReq, memRdy, wRd, wWreg, branch,
    input  pcEn, enIfid, enIdex, enExmem, enMemwb,
           flushIfid, flushIdex, flushExmem, flushMemwb, fwdA, fwdB
  );

  modport slave (
    input  dRs, dRt, dUseRs, dUseRt, eRs, eRt, eRd, eWreg, eReg2reg,
           mRd, mWreg, mReg2reg, mMemReq, memRdy, wRd, wWreg, branch,
    output pcEn, enIfid, enIdex, enExmem, enMemwb,
           flushIfid, flushIdex, flushExmem, flushMemwb, fwdA, fwdB
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: load-use stalls, branch
// flushes, EX-stage forwarding and data-memory wait with a sticky timeout error.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pipe_hazard_if.slave     bus,
  output logic             o_memErr,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stallCnt
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_LDSTALL = 2'b01;
  localparam logic [1:0] ST_MEMWAIT = 2'b10;
  localparam logic [1:0] ST_ERR     = 2'b11;
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [7:0]       r_waitCnt;
  logic             r_memErr;
  logic [CNT_W-1:0] r_stallCnt;

  logic [1:0] w_nextState;
  logic [1:0] w_fwdA, w_fwdB;
  logic       w_memWait, w_loadUse, w_timeout;

  // EX/MEM result beats MEM/WB; a load in MEM has no value to forward yet.
  function automatic logic [1:0] fwdSel(input logic [4:0] src, input logic mW,
                                        input logic mLd, input logic [4:0] mR,
                                        input logic wW, input logic [4:0] wR);
    if (mW && !mLd && mR != 5'd0 && mR == src) return 2'b10;
    if (wW && wR != 5'd0 && wR == src)          return 2'b01;
    return 2'b00;
  endfunction

  assign w_fwdA    = fwdSel(bus.eRs, bus.mWreg, bus.mReg2reg, bus.mRd, bus.wWreg, bus.wRd);
  assign w_fwdB    = fwdSel(bus.eRt, bus.mWreg, bus.mReg2reg, bus.mRd, bus.wWreg, bus.wRd);
  assign w_memWait = bus.mMemReq && !bus.memRdy;
  assign w_timeout = (r_waitCnt == WAIT_LAST);
  assign w_loadUse = bus.eWreg && bus.eReg2reg && bus.eRd != 5'd0 &&
                     ((bus.dUseRs && bus.dRs == bus.eRd) ||
                      (bus.dUseRt && bus.dRt == bus.eRd));

  always_comb begin
    w_nextState    = r_state;
    bus.pcEn       = 1'b1;
    bus.enIfid     = 1'b1;
    bus.enIdex     = 1'b1;
    bus.enExmem    = 1'b1;
    bus.enMemwb    = 1'b1;
    bus.flushIfid  = 1'b0;
    bus.flushIdex  = 1'b0;
    bus.flushExmem = 1'b0;
    bus.flushMemwb = 1'b0;
    bus.fwdA       = w_fwdA;
    bus.fwdB       = w_fwdB;
    if (i_rst) begin
      {bus.pcEn, bus.enIfid, bus.enIdex, bus.enExmem, bus.enMemwb} = 5'b00000;
      {bus.flushIfid, bus.flushIdex, bus.flushExmem, bus.flushMemwb} = 4'b1111;
      bus.fwdA    = 2'b00;
      bus.fwdB    = 2'b00;
      w_nextState = ST_RUN;
    end else if (r_state == ST_ERR) begin
      {bus.pcEn, bus.enIfid, bus.enIdex, bus.enExmem, bus.enMemwb} = 5'b00000;
      bus.fwdA = 2'b00;
      bus.fwdB = 2'b00;
    end else if (w_memWait) begin
      // Freeze everything upstream of MEM; WB keeps draining with bubbles.
      {bus.pcEn, bus.enIfid, bus.enIdex, bus.enExmem} = 4'b0000;
      bus.flushMemwb = 1'b1;
      w_nextState    = w_timeout ? ST_ERR : ST_MEMWAIT;
    end else if (bus.branch) begin
      bus.flushIfid = 1'b1;
      bus.flushIdex = 1'b1;
      w_nextState   = ST_RUN;
    end else if (w_loadUse) begin
      bus.pcEn      = 1'b0;
      bus.enIfid    = 1'b0;
      bus.flushIdex = 1'b1;
      w_nextState   = ST_LDSTALL;
    end else begin
      w_nextState = ST_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_RUN;
      r_waitCnt  <= 8'd0;
      r_memErr   <= 1'b0;
      r_stallCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state != ST_ERR) begin
        r_waitCnt <= w_memWait ? r_waitCnt + 8'd1 : 8'd0;
        if (w_memWait && w_timeout)
          r_memErr <= 1'b1;
        if (!bus.pcEn && r_stallCnt != {CNT_W{1'b1}})
          r_stallCnt <= r_stallCnt + 1'b1;
      end
    end
  end

  assign o_memErr   = r_memErr;
  assign o_state    = r_state;
  assign o_stallCnt = r_stallCnt;

endmodule
